id_ex_stage: RTL and testbench

ID_EX_STAGE -- requirements
Module: id_ex_stage

---
 rtl/id_ex_pkg.sv | 48 ++++
 rtl/pipe_skid_buf.sv | 78 +++++++
 rtl/id_ex_stage.sv | 101 ++++++++++
 tb/tb_id_ex_stage.sv | 306 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/id_ex_pkg.sv
// Types shared by the ID/EX and EX/MEM pipeline registers: control bundle,
// default-width payload record and the bubble (NOP) masking helper.
package id_ex_pkg;

  localparam int ALU_OP_W  = 6;
  localparam int DEF_LANES = 4;
  localparam int DEF_ADDR_W = 5;
  localparam int DEF_IMM_W = 32;

  typedef struct packed {
    logic                reg_dst;
    logic                branch;
    logic                write_signal;
    logic                mem_to_reg;
    logic                alu_src;
    logic                reg_write;
    logic                is_mem_inst;
    logic                is_word;
    logic                halted;
    logic [ALU_OP_W-1:0] alu_op;
  } ctrl_t;

  // Payload layout at the default widths; stages built with other widths
  // declare the same field order resized to their own parameters.
  typedef struct packed {
    ctrl_t                  ctrl;
    logic [DEF_IMM_W-1:0]   pc_plus_4;
    logic [DEF_IMM_W-1:0]   imm;
    logic [DEF_LANES*8-1:0] rs_data;
    logic [DEF_LANES*8-1:0] rt_data;
    logic [DEF_ADDR_W-1:0]  rt_addr;
    logic [DEF_ADDR_W-1:0]  rd_addr;
  } ex_payload_t;

  // A bubble must never commit architectural state downstream.
  function automatic ctrl_t bubble_mask(input ctrl_t c, input logic valid);
    ctrl_t m;
    m = c;
    if (!valid) begin
      m.reg_write    = 1'b0;
      m.write_signal = 1'b0;
      m.branch       = 1'b0;
      m.halted       = 1'b0;
    end
    return m;
  endfunction

endpackage

// File: rtl/pipe_skid_buf.sv
// Generic pipeline register for any payload type T, with flush.
// Default: single entry. ID_EX_SKID_EN: two-entry skid buffer, registered in_ready.
module pipe_skid_buf #(
  parameter type T = logic [7:0]
) (
  input  logic clk,
  input  logic rst_n,
  input  logic flush,
  input  logic accept_en,
  input  logic in_valid,
  output logic in_ready,
  input  T     in_data,
  output logic out_valid,
  input  logic out_ready,
  output T     out_data
);

  // Handshake: a beat moves on an edge where valid && ready on that side;
  // a presented output beat stays unchanged until out_ready is seen, and
  // flush drops every held beat while refusing the one offered that cycle.
  logic accept;
  assign accept = in_valid && in_ready;

`ifdef ID_EX_SKID_EN

  logic skid_valid;
  T     skid_data;

  // Depends only on state and flush; out_ready never reaches in_ready.
  assign in_ready = accept_en && !flush && !skid_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid  <= 1'b0;
      out_data   <= '0;
      skid_valid <= 1'b0;
      skid_data  <= '0;
    end else if (flush) begin
      out_valid  <= 1'b0;
      skid_valid <= 1'b0;
    end else if (out_valid && !out_ready) begin
      if (accept) begin
        skid_valid <= 1'b1;
        skid_data  <= in_data;
      end
    end else if (skid_valid) begin
      out_valid  <= 1'b1;
      out_data   <= skid_data;
      skid_valid <= 1'b0;
    end else if (accept) begin
      out_valid <= 1'b1;
      out_data  <= in_data;
    end else begin
      out_valid <= 1'b0;
    end
  end

`else

  assign in_ready = accept_en && !flush && (!out_valid || out_ready);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (accept) begin
      out_valid <= 1'b1;
      out_data  <= in_data;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

`endif

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register: packs decode outputs into one payload, holds it
// through back-pressure and flush, and latches a sticky halt. Option: ID_EX_SKID_EN.
module id_ex_stage
  import id_ex_pkg::*;
#(
  parameter int LANES  = 4,
  parameter int ADDR_W = 5,
  parameter int IMM_W  = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 flush,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  ctrl_t                in_ctrl,
  input  logic [IMM_W-1:0]     in_pc_plus_4,
  input  logic [IMM_W-1:0]     in_imm,
  input  logic [LANES*8-1:0]   in_rs_data,
  input  logic [LANES*8-1:0]   in_rt_data,
  input  logic [ADDR_W-1:0]    in_rt_addr,
  input  logic [ADDR_W-1:0]    in_rd_addr,
  output logic                 out_valid,
  input  logic                 out_ready,
  output ctrl_t                out_ctrl,
  output logic [IMM_W-1:0]     out_pc_plus_4,
  output logic [IMM_W-1:0]     out_imm,
  output logic [LANES*8-1:0]   out_rs_data,
  output logic [LANES*8-1:0]   out_rt_data,
  output logic [ADDR_W-1:0]    out_rt_addr,
  output logic [ADDR_W-1:0]    out_rd_addr,
  output logic                 halted_seen
);

  // Same field order as ex_payload_t, sized by this instance's parameters.
  typedef struct packed {
    ctrl_t                ctrl;
    logic [IMM_W-1:0]     pc_plus_4;
    logic [IMM_W-1:0]     imm;
    logic [LANES*8-1:0]   rs_data;
    logic [LANES*8-1:0]   rt_data;
    logic [ADDR_W-1:0]    rt_addr;
    logic [ADDR_W-1:0]    rd_addr;
  } payload_t;

  payload_t pl_in;
  payload_t pl_out;
  logic     init_done;
  logic     accept_en;
  logic     buf_out_valid;

  // init_done keeps the stage closed for the first cycle after reset release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      init_done   <= 1'b0;
      halted_seen <= 1'b0;
    end else begin
      init_done <= 1'b1;
      if (in_valid && in_ready && in_ctrl.halted) begin
        halted_seen <= 1'b1;
      end
    end
  end

  assign accept_en = init_done && !halted_seen;

  always_comb begin
    pl_in           = '0;
    pl_in.ctrl      = in_ctrl;
    pl_in.pc_plus_4 = in_pc_plus_4;
    pl_in.imm       = in_imm;
    pl_in.rs_data   = in_rs_data;
    pl_in.rt_data   = in_rt_data;
    pl_in.rt_addr   = in_rt_addr;
    pl_in.rd_addr   = in_rd_addr;
  end

  pipe_skid_buf #(
    .T(payload_t)
  ) u_buf (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .accept_en (accept_en),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (pl_in),
    .out_valid (buf_out_valid),
    .out_ready (out_ready),
    .out_data  (pl_out)
  );

  assign out_valid     = buf_out_valid;
  assign out_ctrl      = bubble_mask(pl_out.ctrl, buf_out_valid);
  assign out_pc_plus_4 = pl_out.pc_plus_4;
  assign out_imm       = pl_out.imm;
  assign out_rs_data   = pl_out.rs_data;
  assign out_rt_data   = pl_out.rt_data;
  assign out_rt_addr   = pl_out.rt_addr;
  assign out_rd_addr   = pl_out.rd_addr;

endmodule

// File: tb/tb_id_ex_stage.sv
// Bench for id_ex_stage built with 8 lanes and 6-bit register addresses;
// a queue-based reference model tracks every held beat.
`timescale 1ns/1ps
module tb_id_ex_stage;
  import id_ex_pkg::*;

  localparam int LANES  = 8;
  localparam int ADDR_W = 6;
  localparam int IMM_W  = 32;
  localparam int DW     = LANES * 8;
`ifdef ID_EX_SKID_EN
  localparam bit SKID = 1'b1;
`else
  localparam bit SKID = 1'b0;
`endif

  typedef struct packed {
    ctrl_t              ctrl;
    logic [IMM_W-1:0]   pc4;
    logic [IMM_W-1:0]   imm;
    logic [DW-1:0]      rs;
    logic [DW-1:0]      rt;
    logic [ADDR_W-1:0]  rt_a;
    logic [ADDR_W-1:0]  rd_a;
  } beat_t;

  // ---------------- clock / reset / DUT ----------------
  logic clk, rst_n, flush, in_valid, in_ready, out_valid, out_ready, halted_seen;
  ctrl_t out_ctrl;
  logic [IMM_W-1:0]  out_pc_plus_4, out_imm;
  logic [DW-1:0]     out_rs_data, out_rt_data;
  logic [ADDR_W-1:0] out_rt_addr, out_rd_addr;
  beat_t drv, obs;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign obs = {out_ctrl, out_pc_plus_4, out_imm, out_rs_data, out_rt_data, out_rt_addr, out_rd_addr};

  id_ex_stage #(.LANES(LANES), .ADDR_W(ADDR_W), .IMM_W(IMM_W)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .flush         (flush),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_ctrl       (drv.ctrl),
    .in_pc_plus_4  (drv.pc4),
    .in_imm        (drv.imm),
    .in_rs_data    (drv.rs),
    .in_rt_data    (drv.rt),
    .in_rt_addr    (drv.rt_a),
    .in_rd_addr    (drv.rd_a),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_ctrl      (out_ctrl),
    .out_pc_plus_4 (out_pc_plus_4),
    .out_imm       (out_imm),
    .out_rs_data   (out_rs_data),
    .out_rt_data   (out_rt_data),
    .out_rt_addr   (out_rt_addr),
    .out_rd_addr   (out_rd_addr),
    .halted_seen   (halted_seen)
  );

  // ---------------- comparison helpers ----------------
  int n_vec = 0;
  int n_fail = 0;

  task automatic check_bit(input string name, input logic act, input logic exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b, expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_word(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_beat(input string name, input beat_t act, input beat_t exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- scoreboard / reference model ----------------
  // The stage is modelled as an ordered store of accepted beats with a
  // capacity: 1 entry (may be replaced in the cycle it drains) or 2 entries.
  beat_t exp_q[$];
  int    since_rst = 0;
  bit    halt_m = 1'b0;
  bit    exp_rdy;
  int    halt_out = 0;

  always @(negedge clk) begin
    if (!rst_n) begin
      check_bit("rst_out_valid", out_valid, 1'b0);
      check_bit("rst_in_ready", in_ready, 1'b0);
      check_bit("rst_halted_seen", halted_seen, 1'b0);
      check_beat("rst_payload", obs, '0);
      exp_q.delete();
      since_rst = 0;
      halt_m = 1'b0;
    end else begin
      exp_rdy = (since_rst > 0) && !halt_m && !flush &&
                (SKID ? (exp_q.size() < 2) : (exp_q.size() == 0 || out_ready));
      check_bit("in_ready", in_ready, exp_rdy);
      check_bit("out_valid", out_valid, exp_q.size() != 0);
      check_bit("halted_seen", halted_seen, halt_m);
      if (exp_q.size() != 0) begin
        check_beat("out_payload", obs, exp_q[0]);
      end else begin
        check_bit("bubble_nop", out_ctrl.reg_write | out_ctrl.write_signal |
                                out_ctrl.branch | out_ctrl.halted, 1'b0);
      end
      if (out_valid && out_ready && exp_q.size() != 0) begin
        if (out_ctrl.halted) halt_out++;
        void'(exp_q.pop_front());
      end
      if (flush) begin
        exp_q.delete();
      end else if (in_valid && in_ready) begin
        exp_q.push_back(drv);
        if (drv.ctrl.halted) halt_m = 1'b1;
      end
      since_rst++;
    end
  end

  // ---------------- driver tasks ----------------
  function automatic beat_t rand_beat();
    beat_t b;
    logic [31:0] r;
    r = $urandom;
    b.ctrl = r[$bits(ctrl_t)-1:0];
    b.ctrl.halted = 1'b0;
    b.pc4 = $urandom;
    b.imm = $urandom;
    b.rs = {$urandom, $urandom};
    b.rt = {$urandom, $urandom};
    r = $urandom;
    b.rt_a = r[ADDR_W-1:0];
    b.rd_a = r[ADDR_W+7:8];
    return b;
  endfunction

  task automatic tick(output bit fired);
    @(negedge clk);
    fired = in_valid && in_ready;
    @(posedge clk);
    #1;
  endtask

  task automatic send(input beat_t b, input int max_cyc);
    bit f;
    int n;
    f = 1'b0;
    n = 0;
    drv = b;
    in_valid = 1'b1;
    while (!f && n < max_cyc) begin
      tick(f);
      n++;
    end
    if (!f) check_bit("send_timeout", 1'b0, 1'b1);
    in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    bit f;
    in_valid = 1'b0;
    for (int i = 0; i < n; i++) tick(f);
  endtask

  // ---------------- stimulus ----------------
  bit    f;
  int    idx;
  beat_t beats[3];
  beat_t a, b, h, d;

  initial begin
    rst_n = 1'b0;
    flush = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b0;
    drv = '0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    check_bit("ready_first_cycle", in_ready, 1'b0);

    // Streaming at full rate with immediates 0x10..0x14
    out_ready = 1'b1;
    drv = rand_beat();
    in_valid = 1'b1;
    tick(f);
    for (int i = 0; i < 5; i++) begin
      drv = rand_beat();
      drv.imm = 32'h10 + i;
      in_valid = 1'b1;
      tick(f);
      check_bit("stream_accept", f, 1'b1);
    end
    idle(3);

    // Back-pressure: A, B, C offered while out_ready is low for three cycles
    for (int i = 0; i < 3; i++) beats[i] = rand_beat();
    idx = 0;
    for (int cyc = 0; cyc < 20 && idx < 3; cyc++) begin
      out_ready = (cyc >= 3);
      drv = beats[idx];
      in_valid = 1'b1;
      tick(f);
      if (f) idx++;
    end
    check_bit("abc_all_sent", idx == 3, 1'b1);
    out_ready = 1'b1;
    idle(4);

    // Randomised traffic with occasional flushes
    for (int i = 0; i < 600; i++) begin
      drv = rand_beat();
      in_valid = ($urandom_range(0, 9) < 7);
      out_ready = ($urandom_range(0, 9) < 6);
      flush = ($urandom_range(0, 19) == 0);
      tick(f);
    end
    flush = 1'b0;
    out_ready = 1'b1;
    idle(4);

    // Flush while A is held and B is offered
    out_ready = 1'b0;
    a = rand_beat();
    a.ctrl.reg_write = 1'b1;
    send(a, 5);
    b = rand_beat();
    b.ctrl.reg_write = 1'b1;
    drv = b;
    in_valid = 1'b1;
    flush = 1'b1;
    tick(f);
    check_bit("flush_refuses_beat", f, 1'b0);
    flush = 1'b0;
    in_valid = 1'b0;
    check_bit("flush_out_valid", out_valid, 1'b0);
    check_bit("flush_reg_write", out_ctrl.reg_write, 1'b0);
    out_ready = 1'b1;
    idle(4);

    // Halted beat: sticky flag, intake closed, beat still emitted once
    h = rand_beat();
    h.ctrl.halted = 1'b1;
    send(h, 5);
    check_bit("halted_seen_set", halted_seen, 1'b1);
    for (int i = 0; i < 6; i++) begin
      drv = rand_beat();
      in_valid = 1'b1;
      tick(f);
      check_bit("halt_blocks_intake", f, 1'b0);
    end
    in_valid = 1'b0;
    idle(2);
    check_word("halted_emitted_once", 64'(halt_out), 64'd1);

    // Asynchronous reset while a beat is stalled at the output
    @(posedge clk);
    #1 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    out_ready = 1'b0;
    d = rand_beat();
    d.rs = 64'hDEAD_BEEF;
    d.rd_a = 6'h3F;
    send(d, 5);
    tick(f);
    check_word("stalled_rs_data", out_rs_data, 64'hDEAD_BEEF);
    check_word("stalled_rd_addr", 64'(out_rd_addr), 64'h3F);
    #2 rst_n = 1'b0;
    #1;
    check_bit("async_rst_out_valid", out_valid, 1'b0);
    check_word("async_rst_rs_data", out_rs_data, 64'h0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    out_ready = 1'b1;
    idle(3);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

  initial begin
    #100000;
    n_fail++;
    $display("FAIL watchdog: got timeout, expected completion");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
